// File: rtl/bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bridge_arbiter
// Brief    : Two-master arbiter for the timer bridge slave port. One
//            transaction at a time: grant, one bus cycle, one-cycle ack.
//            Optional macro BRIDGE_ARB_ROUND_ROBIN_EN selects round-robin
//            tie-break; otherwise master 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [2:0]  m0_dm_mode,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [2:0]  m1_dm_mode,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [2:0]  bus_dm_mode,
    output logic [31:0] bus_wdata,
    output logic        bus_stop,
    input  logic [31:0] bus_rdata,
    input  logic        bus_valid
);

    // Mirrors DM_NONE from dm.h
    localparam logic [2:0] c_DM_NONE = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        r_winner;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [2:0]  r_dm_mode;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any_req;
    logic        w_tie_pick;
    logic        w_pick;
    logic        w_idle;
    logic        w_busy;
    logic        w_resp;

    assign w_idle    = (r_state == S_IDLE);
    assign w_busy    = (r_state == S_BUSY);
    assign w_resp    = (r_state == S_RESP);
    assign w_any_req = m0_req | m1_req;

`ifdef BRIDGE_ARB_ROUND_ROBIN_EN
    assign w_tie_pick = ~r_last_grant;
`else
    // last_grant is still tracked but never influences the tie-break
    assign w_tie_pick = 1'b0 & r_last_grant;
`endif

    assign w_pick = (m0_req & m1_req) ? w_tie_pick : m1_req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
            S_BUSY:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_dm_mode    <= 3'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && w_any_req) begin
                r_winner     <= w_pick;
                r_last_grant <= w_pick;
                r_addr       <= w_pick ? m1_addr    : m0_addr;
                r_wdata      <= w_pick ? m1_wdata   : m0_wdata;
                r_we         <= w_pick ? m1_we      : m0_we;
                r_dm_mode    <= w_pick ? m1_dm_mode : m0_dm_mode;
            end
            if (w_busy) begin
                r_rdata <= bus_rdata;
                r_err   <= ~bus_valid;
            end
        end
    end

    assign m0_gnt = w_idle & w_any_req & ~w_pick;
    assign m1_gnt = w_idle & w_any_req &  w_pick;

    assign m0_ack   = w_resp & ~r_winner;
    assign m1_ack   = w_resp &  r_winner;
    assign m0_rdata = m0_ack ? r_rdata : 32'd0;
    assign m1_rdata = m1_ack ? r_rdata : 32'd0;
    assign m0_err   = m0_ack & r_err;
    assign m1_err   = m1_ack & r_err;

    // Bus is only driven during the single access cycle
    assign bus_addr    = w_busy ? r_addr    : 32'd0;
    assign bus_wdata   = w_busy ? r_wdata   : 32'd0;
    assign bus_we      = w_busy & r_we;
    assign bus_dm_mode = w_busy ? r_dm_mode : c_DM_NONE;
    assign bus_stop    = ~w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bridge_arbiter
// Brief    : Self-checking bench for bridge_arbiter with a timer-bridge
//            stand-in and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_arbiter;

    localparam logic [2:0] DM_NONE = 3'd0;
    localparam logic [2:0] DM_H    = 3'd2;
    localparam logic [2:0] DM_W    = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [2:0]  m0_dm_mode = '0, m1_dm_mode = '0;
    logic        m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_stop, bus_valid;
    logic [2:0]  bus_dm_mode;

    bridge_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_dm_mode(m0_dm_mode),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_dm_mode(m1_dm_mode),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_dm_mode(bus_dm_mode),
        .bus_wdata(bus_wdata), .bus_stop(bus_stop),
        .bus_rdata(bus_rdata), .bus_valid(bus_valid)
    );

    // Timer register map: 0x7F00 timer0, 0x7F10 timer1; CTRL/PRESET/COUNT
    function automatic logic legal(input logic [31:0] a, input logic we, input logic [2:0] dm);
        logic [3:0] off;
        off = a[3:0];
        return ((a >> 5) == 32'h3F8) && (off == 4'h0 || off == 4'h4 || off == 4'h8)
               && (dm == DM_W) && !(we && off == 4'h8);
    endfunction

    function automatic logic [2:0] ridx(input logic [31:0] a);
        return {a[4], a[3:2]};
    endfunction

    // Bridge stand-in: noise whenever stop is high
    logic [31:0] br_regs [8];
    logic [31:0] junk = 32'h0;
    logic        junk_v = 1'b0;
    assign bus_rdata = bus_stop ? junk :
                       (legal(bus_addr, bus_we, bus_dm_mode) ? br_regs[ridx(bus_addr)] : 32'h0);
    assign bus_valid = bus_stop ? junk_v : legal(bus_addr, bus_we, bus_dm_mode);

    always @(posedge clk) begin
        junk   <= $urandom;
        junk_v <= 1'($urandom_range(0, 1));
        if (rst) begin
            for (int i = 0; i < 8; i++) br_regs[i] <= 32'h0;
        end else if (!bus_stop && bus_we && legal(bus_addr, bus_we, bus_dm_mode)) begin
            br_regs[ridx(bus_addr)] <= bus_wdata;
        end
    end

    // Reference model state
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_regs [8];
    int          gap;
    logic        ref_last;
    logic        cur_id;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_we, e_err;
    logic [2:0]  e_dm;

    logic        p_req   [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic        p_we    [2];
    logic [2:0]  p_dm    [2];

    localparam int NADDR = 10;
    logic [31:0] addr_tab [NADDR] = '{32'h7F00, 32'h7F04, 32'h7F08, 32'h7F0C, 32'h7F10,
                                      32'h7F14, 32'h7F18, 32'h7F1C, 32'h7F02, 32'h1000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic we,
                         input logic [2:0] dm, input logic [31:0] wd);
        p_req[m] = 1'b1; p_addr[m] = a; p_we[m] = we; p_dm[m] = dm; p_wdata[m] = wd;
    endtask

    task automatic model_reset();
        gap = 0;
        ref_last = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 32'h0;
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
    endtask

    task automatic cycle(input logic r_in, input int pct);
        logic [1:0]  eg, ea;
        logic [31:0] erd [2];
        logic        eer [2];
        logic        w;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (!p_req[m] && ($urandom_range(1, 100) <= pct)) begin
                issue(m, addr_tab[$urandom_range(0, NADDR - 1)], 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0) ? DM_W : 3'($urandom_range(0, 7)),
                      $urandom);
            end
        end
        rst = r_in;
        m0_req = p_req[0]; m0_addr = p_addr[0]; m0_we = p_we[0];
        m0_dm_mode = p_dm[0]; m0_wdata = p_wdata[0];
        m1_req = p_req[1]; m1_addr = p_addr[1]; m1_we = p_we[1];
        m1_dm_mode = p_dm[1]; m1_wdata = p_wdata[1];
        @(negedge clk);

        eg = 2'b00; ea = 2'b00;
        erd[0] = 32'h0; erd[1] = 32'h0; eer[0] = 1'b0; eer[1] = 1'b0;
        if (gap == 1) begin
            ea[cur_id]  = 1'b1;
            erd[cur_id] = e_rdata;
            eer[cur_id] = e_err;
        end
        if (gap == 0 && (p_req[0] || p_req[1])) begin
`ifdef BRIDGE_ARB_ROUND_ROBIN_EN
            w = (p_req[0] && p_req[1]) ? !ref_last : p_req[1];
`else
            w = (p_req[0] && p_req[1]) ? 1'b0 : p_req[1];
`endif
            eg[w]   = 1'b1;
            cur_id  = w;
            e_addr  = p_addr[w]; e_we = p_we[w]; e_dm = p_dm[w]; e_wdata = p_wdata[w];
            e_err   = !legal(e_addr, e_we, e_dm);
            e_rdata = e_err ? 32'h0 : ref_regs[ridx(e_addr)];
            if (!e_err && e_we) ref_regs[ridx(e_addr)] = e_wdata;
            ref_last = w;
        end

        chk("m0_gnt", 32'(m0_gnt), 32'(eg[0]));
        chk("m1_gnt", 32'(m1_gnt), 32'(eg[1]));
        chk("m0_ack", 32'(m0_ack), 32'(ea[0]));
        chk("m1_ack", 32'(m1_ack), 32'(ea[1]));
        chk("m0_rdata", m0_rdata, erd[0]);
        chk("m1_rdata", m1_rdata, erd[1]);
        chk("m0_err", 32'(m0_err), 32'(eer[0]));
        chk("m1_err", 32'(m1_err), 32'(eer[1]));
        chk("bus_stop", 32'(bus_stop), (gap == 2) ? 32'd0 : 32'd1);
        chk("bus_addr", bus_addr, (gap == 2) ? e_addr : 32'h0);
        chk("bus_we", 32'(bus_we), (gap == 2) ? 32'(e_we) : 32'd0);
        chk("bus_dm_mode", 32'(bus_dm_mode), (gap == 2) ? 32'(e_dm) : 32'(DM_NONE));
        chk("bus_wdata", bus_wdata, (gap == 2) ? e_wdata : 32'h0);

        if (gap == 1) p_req[cur_id] = 1'b0;
        if (eg != 2'b00) gap = 3;
        if (gap > 0) gap--;
        if (r_in) model_reset();
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 0);
    endtask

    initial begin
        model_reset();
        for (int m = 0; m < 2; m++) begin
            p_addr[m] = 32'h0; p_wdata[m] = 32'h0; p_we[m] = 1'b0; p_dm[m] = DM_NONE;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        cycle(1'b1, 0);
        cycle(1'b1, 0);

        // Preset write then read back
        issue(0, 32'h7F04, 1'b1, DM_W, 32'h10); run(4);
        issue(0, 32'h7F04, 1'b0, DM_W, 32'h0);  run(4);

        // Simultaneous reads
        issue(0, 32'h7F04, 1'b0, DM_W, 32'h0);
        issue(1, 32'h7F14, 1'b0, DM_W, 32'h0);
        run(8);

        // COUNT write is illegal and must not land
        issue(1, 32'h7F18, 1'b1, DM_W, 32'h5); run(4);
        issue(1, 32'h7F18, 1'b0, DM_W, 32'h0); run(4);

        // Non-word write to CTRL
        issue(0, 32'h7F00, 1'b1, DM_H, 32'h7); run(4);
        issue(0, 32'h7F00, 1'b0, DM_W, 32'h0); run(4);

        // Both masters requesting continuously
        repeat (12) cycle(1'b0, 100);
        run(8);

        repeat (400) cycle(1'b0, 50);
        run(10);

        // Reset during the BUSY cycle of a CTRL write
        issue(0, 32'h7F00, 1'b1, DM_W, 32'h9);
        for (int k = 0; k < 10 && gap != 2; k++) cycle(1'b0, 0);
        chk("reach_busy", 32'(gap), 32'd2);
        cycle(1'b1, 0);
        cycle(1'b0, 0);
        issue(0, 32'h7F00, 1'b0, DM_W, 32'h0); run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
